// File: rtl/cnn_win_pkg.sv
// Shared types and constants for the 5x5 CNN window sequencer.
//   state_t  : frame sequencer states
//   PIX_W    : pixel width of the image ROM / line buffer data
//   DEF_*    : default image geometry and kernel size
//   NUM_WIN  : number of fully-inside windows per frame at default geometry
package cnn_win_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int PIX_W     = 9;
  localparam int DEF_IMG_W = 28;
  localparam int DEF_IMG_H = 28;
  localparam int DEF_K     = 5;
  localparam int NUM_WIN   = (DEF_IMG_W - DEF_K + 1) * (DEF_IMG_H - DEF_K + 1);

endpackage

// File: rtl/win_coord_cnt.sv
// Raster-order row/column counter for the pixel currently at stage 1.
//   clk, rstn : clock, asynchronous active-low reset
//   en        : advance one pixel (column wraps at IMG_W-1, row at IMG_H-1)
//   clr       : synchronous clear to (0,0); has priority over en
//   row, col  : current pixel coordinates
module win_coord_cnt #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/conv_win_ctrl.sv
// Frame sequencer for the KxK CNN window generator.
// Issues image ROM addresses in raster order, shifts the line buffer one
// cycle after ROM data returns, and presents each window lying fully inside
// the image with its top-left coordinates. A stalled window (valid & !ready)
// freezes the whole pipeline.
//   clk, rstn          : clock, asynchronous active-low reset
//   start, abort       : frame start (IDLE only) and synchronous abort
//   busy, done         : frame in progress; one-cycle end-of-frame pulse
//   rom_addr, rom_en   : ROM address and address-register enable (latency 1)
//   lb_shift           : line buffer / column delay shift enable
//   win_valid/ready    : window handshake
//   win_row, win_col   : top-left coordinates of the presented window
//   win_last           : presented window is the last of the frame
module conv_win_ctrl
  import cnn_win_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int K      = DEF_K,
  parameter int ADDR_W = 10,
  parameter int CW     = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  output logic              lb_shift,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [CW-1:0]     win_row,
  output logic [CW-1:0]     win_col,
  output logic              win_last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [CW-1:0]     KM1       = CW'(K - 1);
  localparam logic [CW-1:0]     ROW_LAST  = CW'(IMG_H - 1);
  localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_W - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              s1_v_q, s1_v_d;
  logic              win_valid_q, win_valid_d;
  logic [CW-1:0]     win_row_q, win_row_d;
  logic [CW-1:0]     win_col_q, win_col_d;
  logic              win_last_q, win_last_d;
  logic              done_q, done_d;
  logic [CW-1:0]     s1_row, s1_col;
  logic              adv, hs, start_frame, in_image;

  // A presented-but-unaccepted window freezes every stage.
  assign adv         = !(win_valid_q && !win_ready);
  assign hs          = win_valid_q && win_ready;
  assign start_frame = (state_q == ST_IDLE) && start && !abort;

  // FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_RUN;
        ST_RUN:   if (rom_en && (rom_addr_q == LAST_ADDR)) state_d = ST_DRAIN;
        ST_DRAIN: if (hs && win_last_q) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy   = (state_q != ST_IDLE);
    rom_en = (state_q == ST_RUN) && adv;
  end

  // Issue stage and stage 1
  assign lb_shift = s1_v_q && adv;

  win_coord_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW)
  ) u_s1_coord (
    .clk  (clk),
    .rstn (rstn),
    .en   (lb_shift),
    .clr  (start_frame || abort),
    .row  (s1_row),
    .col  (s1_col)
  );

  // A window is complete once its bottom-right pixel is shifted in; rows and
  // columns below K-1 only fill the line buffer.
  assign in_image = (s1_row >= KM1) && (s1_col >= KM1);

  always_comb begin
    rom_addr_d  = rom_addr_q;
    s1_v_d      = s1_v_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    win_last_d  = win_last_q;
    done_d      = 1'b0;

    if (start_frame) rom_addr_d = '0;
    else if (rom_en && (rom_addr_q != LAST_ADDR)) rom_addr_d = rom_addr_q + 1'b1;

    if (abort)    s1_v_d = 1'b0;
    else if (adv) s1_v_d = rom_en;

    // Window stage; lb_shift implies adv, so a new load never overwrites an
    // unaccepted window.
    if (abort) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end else if (lb_shift && in_image) begin
      win_valid_d = 1'b1;
      win_row_d   = s1_row - KM1;
      win_col_d   = s1_col - KM1;
      win_last_d  = (s1_row == ROW_LAST) && (s1_col == COL_LAST);
    end else if (hs) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end

    done_d = hs && win_last_q && !abort && (state_q == ST_DRAIN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rom_addr_q  <= '0;
      s1_v_q      <= 1'b0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      win_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      s1_v_q      <= s1_v_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      win_last_q  <= win_last_d;
      done_q      <= done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign win_last  = win_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_win_ctrl.sv
// Bench for conv_win_ctrl: frames with fixed, stalled and random win_ready,
// abort, start-while-busy and asynchronous reset mid-frame, checked against
// a raster-order window model and the nominal pipeline latency.
module tb_conv_win_ctrl;
  import cnn_win_pkg::*;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 5;
  localparam int NW    = IMG_W - K + 1;
  localparam int NH    = IMG_H - K + 1;
  localparam int NWIN  = NW * NH;

  logic       clk = 1'b0;
  logic       rstn, start, abort, win_ready;
  logic       busy, done, rom_en, lb_shift, win_valid, win_last;
  logic [9:0] rom_addr;
  logic [4:0] win_row, win_col;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv_win_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_en    (rom_en),
    .lb_shift  (lb_shift),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_last  (win_last)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_rom_en"},    rom_en, 0);
    check({tag, "_lb_shift"},  lb_shift, 0);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_win_last"},  win_last, 0);
    check({tag, "_rom_addr"},  rom_addr, 0);
    check({tag, "_win_row"},   win_row, 0);
    check({tag, "_win_col"},   win_col, 0);
  endtask

  // mode 0: ready always 1; 1: random ready; 2: ready low 10 cycles at window (0,5)
  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      1:       return logic'($urandom_range(0, 1));
      2:       return !(cyc >= 124 && cyc < 134);
      default: return 1'b1;
    endcase
  endfunction

  // Nominal cycle of window idx: its bottom-right pixel index plus 3.
  function automatic int nominal_cycle(input int idx);
    return ((idx / NW) + K - 1) * IMG_W + (idx % NW) + K - 1 + 3;
  endfunction

  // Called at posedge+1; start is driven for cycle 0.
  task automatic run_frame(input int mode, input int abort_cyc, input bit start_in_run,
                           input int rst_cyc);
    int   cyc = 0, idx = 0, n_done = 0, n_last = 0, last_hs = -10, first_v = -1;
    int   stop_cyc = 5000;
    bit   prev_stall = 0;
    logic [4:0] prev_row = '0, prev_col = '0;
    logic [9:0] prev_addr = '0;
    if (abort_cyc >= 0) stop_cyc = abort_cyc + 4;
    start     = 1'b1;
    abort     = 1'b0;
    win_ready = ready_for(mode, 0);
    while (cyc <= stop_cyc) begin
      #3;
      if (prev_stall) begin
        check("stall_valid", win_valid, 1);
        check("stall_row",   win_row, prev_row);
        check("stall_col",   win_col, prev_col);
        check("stall_addr",  rom_addr, prev_addr);
      end
      if (win_valid && !win_ready) check("stall_freeze", {rom_en, lb_shift}, 0);
      if (win_valid && first_v < 0) begin
        first_v = cyc;
        check("first_win_cycle", cyc, 119);
      end
      if (mode == 0 && cyc >= 143 && cyc <= 146 && abort_cyc < 0)
        check("row_wrap_gap", {win_valid, lb_shift}, 1);
      if (mode == 2 && cyc == 124) check("stall_target", {win_valid, win_row, win_col}, {1'b1, 5'd0, 5'd5});
      if (abort_cyc >= 0 && cyc == abort_cyc)
        check("abort_target", {win_valid, win_row, win_col}, {1'b1, 5'd10, 5'd3});
      if (abort_cyc >= 0 && cyc == abort_cyc + 1)
        check("abort_state", {busy, win_valid, rom_en, lb_shift}, 0);
      if (abort_cyc >= 0) check("abort_no_done", done, 0);
      if (win_valid && win_ready) begin
        if (idx < NWIN) begin
          check("win_row",  win_row, idx / NW);
          check("win_col",  win_col, idx % NW);
          check("win_last", win_last, (idx == NWIN - 1));
          if (mode == 0) check("win_cycle", cyc, nominal_cycle(idx));
        end else begin
          check("extra_window", idx, NWIN - 1);
        end
        if (win_last) begin
          n_last++;
          last_hs = cyc;
        end
        idx++;
      end
      if (done) begin
        n_done++;
        check("done_after_last", cyc, last_hs + 1);
        check("busy_after_done", busy, 0);
        if (abort_cyc < 0) stop_cyc = cyc + 2;
      end
      prev_stall = win_valid && !win_ready;
      prev_row   = win_row;
      prev_col   = win_col;
      prev_addr  = rom_addr;

      @(posedge clk);
      #1;
      cyc++;
      if (cyc == rst_cyc) begin
        rstn = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        @(negedge clk);
        rstn  = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
      start     = start_in_run && (cyc == 50);
      abort     = (cyc == abort_cyc);
      win_ready = ready_for(mode, cyc);
    end
    start     = 1'b0;
    abort     = 1'b0;
    win_ready = 1'b1;
    if (abort_cyc >= 0) begin
      check("abort_done_count", n_done, 0);
      check("abort_win_count", idx, 244);
    end else begin
      if (n_done == 0) check("frame_timeout", n_done, 1);
      check("win_count",   idx, NWIN);
      check("done_count",  n_done, 1);
      check("last_count",  n_last, 1);
      check("idle_busy",   busy, 0);
    end
  endtask

  initial begin
    rstn      = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    win_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("num_win_const", NUM_WIN, NWIN);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    // start with abort in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", {busy, rom_en}, 0);

    run_frame(0, -1, 1'b0, -1);   // nominal
    run_frame(0, -1, 1'b1, -1);   // start pulsed during RUN
    run_frame(2, -1, 1'b0, -1);   // 10-cycle backpressure at (0,5)
    run_frame(1, -1, 1'b0, -1);   // random ready
    run_frame(0, 402, 1'b0, -1);  // abort at window (10,3)
    run_frame(0, -1, 1'b0, -1);   // restart after abort
    run_frame(1, -1, 1'b0, 300);  // async reset mid-frame
    run_frame(1, -1, 1'b0, -1);   // frame after reset

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
